wb_commit_stage: RTL



---
 rtl/wb_commit_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: multi-lane writeback/commit stage.
// Retires up to LANES in-order instructions per cycle (lane 0 oldest),
// resolves the oldest exception/ERET in the bundle, raises a one-cycle
// flush after such an event, and serialises committed register writes onto
// the single-entry debug trace port through a small FIFO.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   ms_to_ws_valid         MEM bundle valid; ws_allowin is the stage's accept
//   ms_*                   per-lane bundle fields, lane i at slice [i*W +: W]
//   rf_we/waddr/wdata      register file write port, one slice per lane
//   cp0_*                  exception / ERET request towards CP0
//   ws_flush               registered one-cycle flush of IF/ID/EX/MEM
//   debug_wb_*             trace port, one retired write per cycle
// DW must be at least 32; the trace carries the low 32 bits of a result.
module wb_commit_stage #(
   parameter int LANES       = 2,
   parameter int DW          = 32,
   parameter int TRACE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ms_to_ws_valid,
   output logic                  ws_allowin,
   input  logic [LANES-1:0]      ms_lane_valid,
   input  logic [LANES*32-1:0]   ms_pc,
   input  logic [LANES*4-1:0]    ms_gr_we,
   input  logic [LANES*5-1:0]    ms_dest,
   input  logic [LANES*DW-1:0]   ms_result,
   input  logic [LANES-1:0]      ms_ex,
   input  logic [LANES*5-1:0]    ms_excode,
   input  logic [LANES*32-1:0]   ms_badvaddr,
   input  logic [LANES-1:0]      ms_bd,
   input  logic [LANES-1:0]      ms_eret,
   output logic [LANES*4-1:0]    rf_we,
   output logic [LANES*5-1:0]    rf_waddr,
   output logic [LANES*DW-1:0]   rf_wdata,
   output logic                  cp0_exc,
   output logic [4:0]            cp0_excode,
   output logic [31:0]           cp0_epc,
   output logic                  cp0_bd,
   output logic [31:0]           cp0_badvaddr,
   output logic                  cp0_eret,
   output logic                  ws_flush,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int CW = AW + 1;

   // stage register
   logic                  ws_valid_r;
   logic                  ws_flush_r;
   logic [LANES-1:0]      lane_valid_r, ex_r, bd_r, eret_r;
   logic [LANES*32-1:0]   pc_r, badvaddr_r;
   logic [LANES*4-1:0]    gr_we_r;
   logic [LANES*5-1:0]    dest_r, excode_r;
   logic [LANES*DW-1:0]   result_r;

   // trace FIFO
   logic [31:0]           tq_pc_r   [TRACE_DEPTH];
   logic [3:0]            tq_we_r   [TRACE_DEPTH];
   logic [4:0]            tq_dest_r [TRACE_DEPTH];
   logic [31:0]           tq_data_r [TRACE_DEPTH];
   logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]         count_r;

   logic [CW-1:0]         free_s;
   logic                  ready_go_s, allowin_s, fire_s, pop_s, capture_s;
   logic                  exc_s, eret_s;
   logic                  ev_found_s, ev_ex_s, ev_eret_s, ev_bd_s;
   logic [4:0]            ev_excode_s;
   logic [31:0]           ev_pc_s, ev_badvaddr_s;
   logic [LANES-1:0]      commit_s, push_s;
   logic [AW-1:0]         push_idx_s [LANES];
   logic [CW-1:0]         push_cnt_s;

   // A bundle may only retire when the FIFO can absorb every lane it could push.
   assign free_s     = CW'(TRACE_DEPTH) - count_r;
   assign ready_go_s = (free_s >= CW'(LANES));
   assign allowin_s  = !ws_valid_r || ready_go_s;
   assign fire_s     = ws_valid_r && ready_go_s;
   assign pop_s      = (count_r != {CW{1'b0}});
   assign ws_allowin = allowin_s;

   // Find the oldest lane carrying ex/eret; older valid lanes commit, younger ones die.
   always_comb begin
      ev_found_s    = 1'b0;
      ev_ex_s       = 1'b0;
      ev_eret_s     = 1'b0;
      ev_bd_s       = 1'b0;
      ev_excode_s   = 5'd0;
      ev_pc_s       = 32'd0;
      ev_badvaddr_s = 32'd0;
      commit_s      = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         if (ev_found_s) begin
            commit_s[i] = 1'b0;
         end else if (lane_valid_r[i] && (ex_r[i] || eret_r[i])) begin
            ev_found_s    = 1'b1;
            ev_ex_s       = ex_r[i];
            ev_eret_s     = eret_r[i];
            ev_bd_s       = bd_r[i];
            ev_excode_s   = excode_r[i*5 +: 5];
            ev_pc_s       = pc_r[i*32 +: 32];
            ev_badvaddr_s = badvaddr_r[i*32 +: 32];
         end else begin
            commit_s[i] = lane_valid_r[i];
         end
      end
   end

   // ex wins over eret when both sit on the event lane.
   assign exc_s        = fire_s && ev_found_s && ev_ex_s;
   assign eret_s       = fire_s && ev_found_s && !ev_ex_s && ev_eret_s;
   assign cp0_exc      = exc_s;
   assign cp0_eret     = eret_s;
   assign cp0_excode   = ev_excode_s;
   assign cp0_epc      = ev_pc_s;
   assign cp0_bd       = ev_bd_s;
   assign cp0_badvaddr = ev_badvaddr_s;
   assign ws_flush     = ws_flush_r;

   // Register-file enables only for committing lanes of a firing bundle.
   always_comb begin
      rf_we = {(LANES*4){1'b0}};
      for (int i = 0; i < LANES; i++) begin
         if (fire_s && commit_s[i]) begin
            rf_we[i*4 +: 4] = gr_we_r[i*4 +: 4];
         end else begin
            rf_we[i*4 +: 4] = 4'h0;
         end
      end
   end

   assign rf_waddr = dest_r;
   assign rf_wdata = result_r;

   // Pack this cycle's trace pushes into consecutive slots, lane 0 first.
   always_comb begin
      push_cnt_s = {CW{1'b0}};
      push_s     = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         push_idx_s[i] = wr_ptr_r + push_cnt_s[AW-1:0];
         push_s[i]     = fire_s && commit_s[i] && (gr_we_r[i*4 +: 4] != 4'h0);
         if (push_s[i]) begin
            push_cnt_s = push_cnt_s + CW'(1'b1);
         end else begin
            push_cnt_s = push_cnt_s;
         end
      end
   end

   // Stage valid and flush; an event kills the bundle behind it for two cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_r <= 1'b0;
         ws_flush_r <= 1'b0;
      end else begin
         ws_flush_r <= exc_s || eret_s;
         if (exc_s || eret_s) begin
            ws_valid_r <= 1'b0;
         end else if (ws_flush_r) begin
            ws_valid_r <= 1'b0;
         end else if (allowin_s) begin
            ws_valid_r <= ms_to_ws_valid;
         end else begin
            ws_valid_r <= ws_valid_r;
         end
      end
   end

   assign capture_s = ms_to_ws_valid && allowin_s && !ws_flush_r && !exc_s && !eret_s;

   // Bundle payload; contents are meaningless while ws_valid_r is low.
   always_ff @(posedge clk) begin
      if (capture_s) begin
         lane_valid_r <= ms_lane_valid;
         pc_r         <= ms_pc;
         gr_we_r      <= ms_gr_we;
         dest_r       <= ms_dest;
         result_r     <= ms_result;
         ex_r         <= ms_ex;
         excode_r     <= ms_excode;
         badvaddr_r   <= ms_badvaddr;
         bd_r         <= ms_bd;
         eret_r       <= ms_eret;
      end
   end

   // FIFO bookkeeping; pop uses the pre-push count so a fresh entry waits a cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_r  <= {CW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
      end else begin
         count_r  <= count_r + push_cnt_s - CW'(pop_s);
         wr_ptr_r <= wr_ptr_r + push_cnt_s[AW-1:0];
         rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      end
   end

   // FIFO storage writes.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (push_s[i]) begin
            tq_pc_r[push_idx_s[i]]   <= pc_r[i*32 +: 32];
            tq_we_r[push_idx_s[i]]   <= gr_we_r[i*4 +: 4];
            tq_dest_r[push_idx_s[i]] <= dest_r[i*5 +: 5];
            tq_data_r[push_idx_s[i]] <= result_r[i*DW +: 32];
         end
      end
   end

   assign debug_wb_pc       = tq_pc_r[rd_ptr_r];
   assign debug_wb_rf_wen   = pop_s ? tq_we_r[rd_ptr_r] : 4'h0;
   assign debug_wb_rf_wnum  = tq_dest_r[rd_ptr_r];
   assign debug_wb_rf_wdata = tq_data_r[rd_ptr_r];

endmodule
